demux1to2v_stream: RTL and testbench
====================================

// Module: demux1to2v_stream
// PURPOSE
//  1-to-2 demultiplexer for a wide vector stream; the inverse of the 2:1 vector mux (sel=0 -> port 0, sel=1 -> port 1).
//  Single valid/ready input stream is steered to one of two registered output streams.
//  Routing is packet-locked: sel is sampled on the first beat of a packet and held until the last beat.
//  Sits between a shared source and two independent consumers, with one-entry output buffering per port.
// PARAMETERS
//  WIDTH  100  data width of input and both outputs, in bits
//  CNT_W  8    width of the per-port completed-packet counters
// PORTS
//  clk         input   1        rising-edge clock
//  areset_n    input   1        asynchronous reset, active low
//  in_data     input   WIDTH    input beat data
//  in_valid    input   1        input beat valid
//  in_last     input   1        input beat is the last beat of its packet
//  sel         input   1        destination port; used only on the first beat of a packet
//  in_ready    output  1        input beat accepted when in_valid & in_ready
//  out0_data   output  WIDTH    port 0 data (registered)
//  out0_valid  output  1        port 0 valid
//  out0_last   output  1        port 0 last
//  out0_ready  input   1        port 0 consumer ready
//  out1_data   output  WIDTH    port 1 data (registered)
//  out1_valid  output  1        port 1 valid
//  out1_last   output  1        port 1 last
//  out1_ready  input   1        port 1 consumer ready
//  pkt_cnt0    output  CNT_W    packets completed on port 0 (counted when out0 last beat is accepted)
//  pkt_cnt1    output  CNT_W    packets completed on port 1
// BEHAVIOUR
//  Reset (areset_n=0, asynchronous, any time incl. mid-packet):
//   - state=IDLE, lock_sel=0
//   - outN_valid=0, outN_last=0, outN_data=0, pkt_cntN=0
//   - any partially sent packet is discarded
//  FSM:
//   - IDLE: no packet open; target = sel
//     accepted beat with in_last=0 -> PKT, lock_sel <= sel
//     accepted beat with in_last=1 -> stays IDLE (single-beat packet)
//   - PKT: target = lock_sel; sel is ignored
//     accepted beat with in_last=1 -> IDLE
//  Handshake:
//   - in_ready = ~outT_valid | outT_ready, where T = target port
//     combinational from outT_ready; no combinational path from in_valid
//   - Non-target port readiness never affects in_ready
//  Data path:
//   - Accepted beat is written to outT_data/outT_last and sets outT_valid on the next edge (latency 1 cycle)
//   - outN_valid clears on the edge where outN_ready=1 and no new beat is written to port N
//   - Simultaneous drain and fill of port N: the new beat replaces the old one and valid stays 1
//     full throughput: 1 beat/cycle
//   - Outputs hold data/last stable while valid & ~ready
//   - Non-target port holds its contents unchanged
//  Counters:
//   - pkt_cntN increments by 1 on each out port N transfer with outN_last=1
//   - wraps from 2^CNT_W-1 to 0
//  Boundaries:
//   - sel toggling mid-packet has no effect
//   - in_valid=0 mid-packet keeps state PKT indefinitely
//   - Both ports may hold valid data simultaneously
//   - Data is passed bit-exact at full WIDTH; no truncation or extension
// TESTING
//  - Reset: assert areset_n=0 mid-cycle with both ports valid -> all valids, lasts and counters read 0 immediately, before the next clk edge.
//  - Single-beat steer: in_data=100'h1, sel=0, in_last=1 -> next cycle out0_data=1, out0_valid=1, out1_valid=0; after out0_ready=1, pkt_cnt0=1.
//  - Packet lock: 3-beat packet with beats 0xA, 0xB, 0xC; sel=1 on beat 1, sel=0 on beats 2-3 -> all 3 beats appear on out1; out0_valid stays 0; pkt_cnt1=1.
//  - Back-pressure: out1_ready=0 with a beat held on port 1 and a further port-1 beat pending -> in_ready=0 and out1_data stable for 5 cycles; release out1_ready=1 -> next beat accepted the same cycle.
//  - Throughput: out0_ready=1 constant, 8 back-to-back single-beat packets (alternating 100'h555..5 / 100'hAAA..A, sel=0) -> in_ready=1 every cycle, 8 transfers in 8 cycles, pkt_cnt0=8.
//  - Counter wrap: CNT_W=8, 256 single-beat packets to port 1 -> pkt_cnt1 returns to 0; pkt_cnt0 unchanged.

Source files
------------

// File: rtl/demux1to2v_stream.sv
// demux1to2v_stream
// Steers a single valid/ready vector stream onto one of two registered
// output streams. The destination is chosen by sel on the first beat of a
// packet and is held until that packet's last beat. Each output port has a
// one-entry buffer, and each port counts the packets it has completed.
module demux1to2v_stream #(
    parameter int WIDTH = 100,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             areset_n,

    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    input  logic             in_last,
    input  logic             sel,
    output logic             in_ready,

    output logic [WIDTH-1:0] out0_data,
    output logic             out0_valid,
    output logic             out0_last,
    input  logic             out0_ready,

    output logic [WIDTH-1:0] out1_data,
    output logic             out1_valid,
    output logic             out1_last,
    input  logic             out1_ready,

    output logic [CNT_W-1:0] pkt_cnt0,
    output logic [CNT_W-1:0] pkt_cnt1
);

    typedef enum logic {
        IDLE = 1'b0,
        PKT  = 1'b1
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   lock_sel;
    logic   lock_sel_nxt;

    logic   target;
    logic   accept;
    logic   wr0;
    logic   wr1;
    logic   done0;
    logic   done1;

    // Destination port: live sel between packets, locked sel inside a packet.
    // in_ready depends only on the target port's buffer state and its
    // consumer's ready, never on in_valid or on the other port.
    always_comb begin
        target   = (state == PKT) ? lock_sel : sel;
        in_ready = target ? (~out1_valid | out1_ready)
                          : (~out0_valid | out0_ready);
        accept   = in_valid & in_ready;
        wr0      = accept & ~target;
        wr1      = accept &  target;
        done0    = out0_valid & out0_ready & out0_last;
        done1    = out1_valid & out1_ready & out1_last;
    end

    // Packet FSM next-state: open a packet on a non-last beat accepted in
    // IDLE, close it when its last beat is accepted.
    always_comb begin
        state_nxt    = state;
        lock_sel_nxt = lock_sel;
        case (state)
            IDLE: begin
                if (accept && !in_last) begin
                    state_nxt    = PKT;
                    lock_sel_nxt = sel;
                end
            end
            PKT: begin
                if (accept && in_last) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt    = IDLE;
                lock_sel_nxt = 1'b0;
            end
        endcase
    end

    // Packet FSM state and locked destination register.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state    <= IDLE;
            lock_sel <= 1'b0;
        end else begin
            state    <= state_nxt;
            lock_sel <= lock_sel_nxt;
        end
    end

    // Port 0 buffer: a write replaces the held beat (so a same-cycle drain and
    // fill keeps valid high); a drain with no write only clears valid.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            out0_data  <= '0;
            out0_last  <= 1'b0;
            out0_valid <= 1'b0;
        end else if (wr0) begin
            out0_data  <= in_data;
            out0_last  <= in_last;
            out0_valid <= 1'b1;
        end else if (out0_ready) begin
            out0_valid <= 1'b0;
        end
    end

    // Port 1 buffer, same behaviour as port 0.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            out1_data  <= '0;
            out1_last  <= 1'b0;
            out1_valid <= 1'b0;
        end else if (wr1) begin
            out1_data  <= in_data;
            out1_last  <= in_last;
            out1_valid <= 1'b1;
        end else if (out1_ready) begin
            out1_valid <= 1'b0;
        end
    end

    // Completed-packet counters, incremented when a last beat leaves a port;
    // they wrap naturally at 2^CNT_W.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            pkt_cnt0 <= '0;
            pkt_cnt1 <= '0;
        end else begin
            if (done0) begin
                pkt_cnt0 <= pkt_cnt0 + CNT_W'(1);
            end
            if (done1) begin
                pkt_cnt1 <= pkt_cnt1 + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_demux1to2v_stream.sv
// Testbench for demux1to2v_stream: scoreboard queues per output port are
// filled as beats are accepted and drained as the ports transfer.
module tb_demux1to2v_stream;

    localparam int W = 100;
    localparam int C = 8;

    typedef struct packed {
        logic [W-1:0] d;
        logic         l;
    } beat_t;

    logic         clk = 1'b0;
    logic         areset_n;
    logic [W-1:0] in_data;
    logic         in_valid;
    logic         in_last;
    logic         sel;
    logic         in_ready;
    logic [W-1:0] out0_data;
    logic         out0_valid;
    logic         out0_last;
    logic         out0_ready;
    logic [W-1:0] out1_data;
    logic         out1_valid;
    logic         out1_last;
    logic         out1_ready;
    logic [C-1:0] pkt_cnt0;
    logic [C-1:0] pkt_cnt1;

    beat_t        q0[$];
    beat_t        q1[$];
    logic [C-1:0] exp_cnt0;
    logic [C-1:0] exp_cnt1;
    logic         m_open;
    logic         m_lock;
    int           passed;
    int           total;

    localparam logic [W-1:0] P5 = {25{4'h5}};
    localparam logic [W-1:0] PA = {25{4'hA}};

    demux1to2v_stream #(.WIDTH(W), .CNT_W(C)) dut (
        .clk        (clk),
        .areset_n   (areset_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .sel        (sel),
        .in_ready   (in_ready),
        .out0_data  (out0_data),
        .out0_valid (out0_valid),
        .out0_last  (out0_last),
        .out0_ready (out0_ready),
        .out1_data  (out1_data),
        .out1_valid (out1_valid),
        .out1_last  (out1_last),
        .out1_ready (out1_ready),
        .pkt_cnt0   (pkt_cnt0),
        .pkt_cnt1   (pkt_cnt1)
    );

    always #5 clk = ~clk;

    // Output monitor: a transfer happens at the coming posedge when valid and
    // ready are both high at the negedge before it.
    always @(negedge clk) begin
        if (areset_n) begin
            if (out0_valid && out0_ready) begin
                total++;
                if (q0.size() == 0) begin
                    $display("FAIL port0_unexpected: got data=%h last=%b, expected no beat", out0_data, out0_last);
                end else begin
                    beat_t e;
                    e = q0.pop_front();
                    if ({out0_data, out0_last} !== {e.d, e.l})
                        $display("FAIL port0_beat: got data=%h last=%b, expected data=%h last=%b", out0_data, out0_last, e.d, e.l);
                    else
                        passed++;
                end
            end
            if (out1_valid && out1_ready) begin
                total++;
                if (q1.size() == 0) begin
                    $display("FAIL port1_unexpected: got data=%h last=%b, expected no beat", out1_data, out1_last);
                end else begin
                    beat_t e;
                    e = q1.pop_front();
                    if ({out1_data, out1_last} !== {e.d, e.l})
                        $display("FAIL port1_beat: got data=%h last=%b, expected data=%h last=%b", out1_data, out1_last, e.d, e.l);
                    else
                        passed++;
                end
            end
        end
    end

    // Record an accepted beat against the port the bench's routing model picks.
    task automatic push_beat(input logic [W-1:0] d, input logic l, input logic s);
        logic port;
        beat_t b;
        port = m_open ? m_lock : s;
        if (!m_open && !l) begin
            m_open = 1'b1;
            m_lock = s;
        end else if (m_open && l) begin
            m_open = 1'b0;
        end
        b.d = d;
        b.l = l;
        if (port) begin
            q1.push_back(b);
            if (l) exp_cnt1 = exp_cnt1 + 8'd1;
        end else begin
            q0.push_back(b);
            if (l) exp_cnt0 = exp_cnt0 + 8'd1;
        end
    endtask

    // Present one beat, wait (bounded) for acceptance, then drop in_valid.
    task automatic drive_beat(input logic [W-1:0] d, input logic l, input logic s, output int waited);
        in_data  = d;
        in_last  = l;
        sel      = s;
        in_valid = 1'b1;
        waited   = 0;
        while (1) begin
            @(negedge clk);
            if (in_ready) break;
            waited++;
            if (waited >= 100) begin
                total++;
                $display("FAIL accept_timeout: got in_ready=0 for %0d cycles, expected acceptance", waited);
                in_valid = 1'b0;
                return;
            end
        end
        push_beat(d, l, s);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Wait (bounded) until every expected beat has left the DUT, then let
    // the counters settle one edge.
    task automatic wait_drain();
        int n;
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 600) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (q0.size() != 0 || q1.size() != 0)
            $display("FAIL drain: got %0d/%0d beats still pending, expected 0/0", q0.size(), q1.size());
        else
            passed++;
        @(posedge clk);
        #1;
    endtask

    task automatic check_counts(input string tag);
        total++;
        if (pkt_cnt0 !== exp_cnt0)
            $display("FAIL %s_cnt0: got %0d, expected %0d", tag, pkt_cnt0, exp_cnt0);
        else
            passed++;
        total++;
        if (pkt_cnt1 !== exp_cnt1)
            $display("FAIL %s_cnt1: got %0d, expected %0d", tag, pkt_cnt1, exp_cnt1);
        else
            passed++;
    endtask

    task automatic check_idle_outputs(input string tag);
        total++;
        if ({out0_valid, out1_valid, out0_last, out1_last} !== 4'b0000)
            $display("FAIL %s_flags: got v0=%b v1=%b l0=%b l1=%b, expected all 0", tag, out0_valid, out1_valid, out0_last, out1_last);
        else
            passed++;
        total++;
        if ({pkt_cnt0, pkt_cnt1} !== '0)
            $display("FAIL %s_cnts: got %0d/%0d, expected 0/0", tag, pkt_cnt0, pkt_cnt1);
        else
            passed++;
        total++;
        if ({out0_data, out1_data} !== '0)
            $display("FAIL %s_data: got %h/%h, expected 0/0", tag, out0_data, out1_data);
        else
            passed++;
    endtask

    task automatic test_reset();
        areset_n   = 1'b0;
        in_data    = '0;
        in_valid   = 1'b0;
        in_last    = 1'b0;
        sel        = 1'b0;
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        exp_cnt0   = '0;
        exp_cnt1   = '0;
        m_open     = 1'b0;
        m_lock     = 1'b0;
        #2;
        check_idle_outputs("reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        areset_n = 1'b1;
    endtask

    task automatic test_single_beat();
        int w;
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        drive_beat(100'h1, 1'b1, 1'b0, w);
        @(negedge clk);
        total++;
        if ({out0_valid, out1_valid, out0_last} !== 3'b101 || out0_data !== 100'h1)
            $display("FAIL single_out: got v0=%b v1=%b l0=%b d0=%h, expected v0=1 v1=0 l0=1 d0=1", out0_valid, out1_valid, out0_last, out0_data);
        else
            passed++;
        out0_ready = 1'b1;
        wait_drain();
        total++;
        if (pkt_cnt0 !== 8'd1)
            $display("FAIL single_cnt0: got %0d, expected 1", pkt_cnt0);
        else
            passed++;
    endtask

    task automatic test_packet_lock();
        int w;
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        drive_beat(100'hA, 1'b0, 1'b1, w);
        drive_beat(100'hB, 1'b0, 1'b0, w);
        // Idle gap inside the packet with sel pointing at port 0.
        sel = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        total++;
        if (out0_valid !== 1'b0)
            $display("FAIL lock_gap_v0: got %b, expected 0", out0_valid);
        else
            passed++;
        drive_beat(100'hC, 1'b1, 1'b0, w);
        #0;
        total++;
        if (out0_valid !== 1'b0 || out1_data !== 100'hC)
            $display("FAIL lock_last: got v0=%b d1=%h, expected v0=0 d1=c", out0_valid, out1_data);
        else
            passed++;
        wait_drain();
        check_counts("lock");
    endtask

    task automatic test_back_pressure();
        int w;
        out0_ready = 1'b1;
        out1_ready = 1'b0;
        drive_beat(100'h1234_5678_9ABC, 1'b1, 1'b1, w);
        in_data  = 100'hF_0000_0000_0000_0000_0000_00F1;
        in_last  = 1'b1;
        sel      = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if (in_ready !== 1'b0 || out1_data !== 100'h1234_5678_9ABC || out1_valid !== 1'b1)
                $display("FAIL bp_hold%0d: got rdy=%b v1=%b d1=%h, expected rdy=0 v1=1 d1=123456789abc", i, in_ready, out1_valid, out1_data);
            else
                passed++;
        end
        @(posedge clk);
        #1;
        out1_ready = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1)
            $display("FAIL bp_release: got in_ready=%b, expected 1", in_ready);
        else
            passed++;
        @(negedge clk);
        push_beat(in_data, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_drain();
        check_counts("bp");
    endtask

    task automatic test_back_to_back();
        int w;
        int stalls;
        logic [W-1:0] d;
        out0_ready = 1'b1;
        out1_ready = 1'b0;
        stalls = 0;
        for (int i = 0; i < 8; i++) begin
            d = (i % 2 == 0) ? P5 : PA;
            drive_beat(d, 1'b1, 1'b0, w);
            stalls += w;
        end
        total++;
        if (stalls != 0)
            $display("FAIL b2b_stalls: got %0d stall cycles, expected 0", stalls);
        else
            passed++;
        wait_drain();
        check_counts("b2b");
        total++;
        if (pkt_cnt0 !== 8'd9)
            $display("FAIL b2b_cnt0_abs: got %0d, expected 9", pkt_cnt0);
        else
            passed++;
    endtask

    task automatic test_counter_wrap();
        int w;
        logic [C-1:0] before1;
        out1_ready = 1'b1;
        before1 = exp_cnt1;
        for (int i = 0; i < 256; i++) begin
            drive_beat(W'(i) ^ P5, 1'b1, 1'b1, w);
        end
        wait_drain();
        check_counts("wrap");
        total++;
        if (pkt_cnt1 !== before1)
            $display("FAIL wrap_return: got %0d, expected %0d", pkt_cnt1, before1);
        else
            passed++;
    endtask

    task automatic test_async_reset();
        int w;
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        drive_beat(100'h77, 1'b1, 1'b0, w);
        drive_beat(100'h88, 1'b0, 1'b1, w);
        @(posedge clk);
        #3;
        areset_n = 1'b0;
        #1;
        check_idle_outputs("async_rst");
        q0.delete();
        q1.delete();
        exp_cnt0 = '0;
        exp_cnt1 = '0;
        m_open   = 1'b0;
        m_lock   = 1'b0;
        @(posedge clk);
        #1;
        areset_n   = 1'b1;
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        // The discarded packet must not keep port 1 locked.
        drive_beat(100'h99, 1'b1, 1'b0, w);
        wait_drain();
        check_counts("post_rst");
    endtask

    initial begin
        passed = 0;
        total  = 0;
        test_reset();
        test_single_beat();
        test_packet_lock();
        test_back_pressure();
        test_back_to_back();
        test_counter_wrap();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
